// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding selects, load-use stall detection and per-operand hold
// buffers for a pipeline whose EX stage can be held while MEM/WB drain.
module forwarding_hazard_unit #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int NSRC         = 2,
  parameter int LOAD_FWD_MEM = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NSRC*AW-1:0]   id_rsel,
  input  logic [NSRC-1:0]      id_ruse,
  input  logic [NSRC*AW-1:0]   ex_rsel,
  input  logic [NSRC-1:0]      ex_ruse,
  input  logic [AW-1:0]        ex_wsel,
  input  logic                 ex_wen,
  input  logic                 ex_is_load,
  input  logic [AW-1:0]        mem_wsel,
  input  logic                 mem_wen,
  input  logic                 mem_is_load,
  input  logic [AW-1:0]        wb_wsel,
  input  logic                 wb_wen,
  input  logic [DW-1:0]        wb_wdat,
  input  logic                 ex_hold,
  input  logic                 flush,
  output logic [2*NSRC-1:0]    fsel,
  output logic [NSRC*DW-1:0]   hold_dat,
  output logic                 lu_stall,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic                 haz_err
);

  localparam logic [1:0] SEL_RF   = 2'd0;
  localparam logic [1:0] SEL_WB   = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  localparam bit             MEM_FWD_LOAD = (LOAD_FWD_MEM != 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic            mem_ok;
  logic [NSRC-1:0] ex_mem_hit;
  logic [NSRC-1:0] ex_wb_hit;
  logic [NSRC-1:0] id_ex_hit;
  logic [NSRC-1:0] id_mem_hit;
  logic [NSRC-1:0] hold_v;
  logic [NSRC-1:0] take_wb;
  logic [NSRC-1:0] load_use;
  logic [NSRC-1:0] mem_load_hit;

  // A load sitting in MEM only has its data ready when the pipeline allows it.
  assign mem_ok = !mem_is_load || MEM_FWD_LOAD;

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    logic [AW-1:0] ex_a;
    logic [AW-1:0] id_a;
    logic [1:0]    sel;
    logic          hv_q;
    logic [DW-1:0] hd_q;

    assign ex_a = ex_rsel[i*AW +: AW];
    assign id_a = id_rsel[i*AW +: AW];

    assign ex_mem_hit[i] = ex_ruse[i] && mem_wen && (mem_wsel != '0) && (mem_wsel == ex_a);
    assign ex_wb_hit[i]  = ex_ruse[i] && wb_wen  && (wb_wsel  != '0) && (wb_wsel  == ex_a);
    assign id_ex_hit[i]  = id_ruse[i] && ex_wen  && (ex_wsel  != '0) && (ex_wsel  == id_a);
    assign id_mem_hit[i] = id_ruse[i] && mem_wen && (mem_wsel != '0) && (mem_wsel == id_a);

    always_comb begin
      sel = SEL_RF;
      if (ex_mem_hit[i] && mem_ok) begin
        sel = SEL_MEM;
      end else if (ex_wb_hit[i]) begin
        sel = SEL_WB;
      end else if (hv_q) begin
        sel = SEL_HOLD;
      end
    end

    assign fsel[2*i +: 2] = sel;
    assign take_wb[i]     = (sel == SEL_WB);

    assign load_use[i] = id_ruse[i] &&
                         ((ex_is_load && id_ex_hit[i]) ||
                          (!MEM_FWD_LOAD && mem_is_load && id_mem_hit[i]));

    assign mem_load_hit[i] = ex_mem_hit[i] && mem_is_load;

    // The WB value leaves the pipeline next edge; keep it while EX is held.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        hv_q <= 1'b0;
        hd_q <= '0;
      end else if (flush || !ex_hold) begin
        hv_q <= 1'b0;
      end else if (take_wb[i]) begin
        hv_q <= 1'b1;
        hd_q <= wb_wdat;
      end
    end

    assign hold_v[i]             = hv_q;
    assign hold_dat[i*DW +: DW]  = hd_q;
  end

  assign lu_stall = |load_use;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bubble_cnt <= '0;
      haz_err    <= 1'b0;
    end else begin
      // A held or flushed EX slot does not take the bubble this cycle.
      if (lu_stall && !ex_hold && !flush && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
      if (!MEM_FWD_LOAD && (|mem_load_hit)) begin
        haz_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: two load-forwarding variants plus
// a narrow-counter instance for saturation, all driven from shared inputs.
module tb_forwarding_hazard_unit;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NS = 2;

  logic          CLK;
  logic          nRST;
  logic [NS*AW-1:0] id_rsel;
  logic [NS-1:0]    id_ruse;
  logic [NS*AW-1:0] ex_rsel;
  logic [NS-1:0]    ex_ruse;
  logic [AW-1:0]    ex_wsel;
  logic             ex_wen;
  logic             ex_is_load;
  logic [AW-1:0]    mem_wsel;
  logic             mem_wen;
  logic             mem_is_load;
  logic [AW-1:0]    wb_wsel;
  logic             wb_wen;
  logic [DW-1:0]    wb_wdat;
  logic             ex_hold;
  logic             flush;

  logic [2*NS-1:0]  fsel_a, fsel_b, fsel_c;
  logic [NS*DW-1:0] hold_dat_a, hold_dat_b, hold_dat_c;
  logic             lu_stall_a, lu_stall_b, lu_stall_c;
  logic [15:0]      bubble_a, bubble_b;
  logic [2:0]       bubble_c;
  logic             haz_err_a, haz_err_b, haz_err_c;

  int n_checks = 0;
  int n_fail   = 0;

  forwarding_hazard_unit #(.AW(AW), .DW(DW), .NSRC(NS), .LOAD_FWD_MEM(1), .CNT_W(16)) u_dut_a (
    .CLK(CLK), .nRST(nRST), .id_rsel(id_rsel), .id_ruse(id_ruse),
    .ex_rsel(ex_rsel), .ex_ruse(ex_ruse), .ex_wsel(ex_wsel), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_wsel(mem_wsel), .mem_wen(mem_wen),
    .mem_is_load(mem_is_load), .wb_wsel(wb_wsel), .wb_wen(wb_wen), .wb_wdat(wb_wdat),
    .ex_hold(ex_hold), .flush(flush), .fsel(fsel_a), .hold_dat(hold_dat_a),
    .lu_stall(lu_stall_a), .bubble_cnt(bubble_a), .haz_err(haz_err_a)
  );

  forwarding_hazard_unit #(.AW(AW), .DW(DW), .NSRC(NS), .LOAD_FWD_MEM(0), .CNT_W(16)) u_dut_b (
    .CLK(CLK), .nRST(nRST), .id_rsel(id_rsel), .id_ruse(id_ruse),
    .ex_rsel(ex_rsel), .ex_ruse(ex_ruse), .ex_wsel(ex_wsel), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_wsel(mem_wsel), .mem_wen(mem_wen),
    .mem_is_load(mem_is_load), .wb_wsel(wb_wsel), .wb_wen(wb_wen), .wb_wdat(wb_wdat),
    .ex_hold(ex_hold), .flush(flush), .fsel(fsel_b), .hold_dat(hold_dat_b),
    .lu_stall(lu_stall_b), .bubble_cnt(bubble_b), .haz_err(haz_err_b)
  );

  forwarding_hazard_unit #(.AW(AW), .DW(DW), .NSRC(NS), .LOAD_FWD_MEM(1), .CNT_W(3)) u_dut_c (
    .CLK(CLK), .nRST(nRST), .id_rsel(id_rsel), .id_ruse(id_ruse),
    .ex_rsel(ex_rsel), .ex_ruse(ex_ruse), .ex_wsel(ex_wsel), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .mem_wsel(mem_wsel), .mem_wen(mem_wen),
    .mem_is_load(mem_is_load), .wb_wsel(wb_wsel), .wb_wen(wb_wen), .wb_wdat(wb_wdat),
    .ex_hold(ex_hold), .flush(flush), .fsel(fsel_c), .hold_dat(hold_dat_c),
    .lu_stall(lu_stall_c), .bubble_cnt(bubble_c), .haz_err(haz_err_c)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rsel = '0; id_ruse = '0; ex_rsel = '0; ex_ruse = '0;
    ex_wsel = '0; ex_wen = 1'b0; ex_is_load = 1'b0;
    mem_wsel = '0; mem_wen = 1'b0; mem_is_load = 1'b0;
    wb_wsel = '0; wb_wen = 1'b0; wb_wdat = '0;
    ex_hold = 1'b0; flush = 1'b0;
  endtask

  // Inputs change 1ns after the rising edge; checks land mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    idle();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #3;
    check("rst_fsel_a",     64'(fsel_a),     64'd0);
    check("rst_fsel_b",     64'(fsel_b),     64'd0);
    check("rst_stall_a",    64'(lu_stall_a), 64'd0);
    check("rst_bubble_a",   64'(bubble_a),   64'd0);
    check("rst_haz_b",      64'(haz_err_b),  64'd0);
    check("rst_hold_dat_a", 64'(hold_dat_a), 64'd0);
    tick();
    nRST = 1'b1;

    // Forwarding priority: op0 reads r3, op1 reads r4
    ex_rsel = {5'd4, 5'd3}; ex_ruse = 2'b11;
    mem_wsel = 5'd3; mem_wen = 1'b1; wb_wsel = 5'd3; wb_wen = 1'b1;
    #1;
    check("fwd_mem_a", 64'(fsel_a), 64'h2);
    check("fwd_mem_b", 64'(fsel_b), 64'h2);
    mem_wen = 1'b0;
    #1;
    check("fwd_wb_a", 64'(fsel_a), 64'h1);
    mem_wen = 1'b1; mem_is_load = 1'b1; wb_wsel = 5'd4;
    #1;
    check("fwd_ldmem_a", 64'(fsel_a), 64'h6);
    check("fwd_ldmem_b", 64'(fsel_b), 64'h4);
    tick();
    check("haz_set_b",   64'(haz_err_b), 64'd1);
    check("haz_clear_a", 64'(haz_err_a), 64'd0);
    ex_rsel = '0; mem_wsel = '0; mem_is_load = 1'b0; wb_wsel = '0;
    #1;
    check("fwd_r0_a", 64'(fsel_a), 64'h0);
    check("fwd_r0_b", 64'(fsel_b), 64'h0);
    tick();
    check("haz_sticky_b", 64'(haz_err_b), 64'd1);

    // Load-use, load forwarding only from WB
    reset_dut();
    id_rsel = {5'd5, 5'd0}; id_ruse = 2'b10;
    ex_wsel = 5'd5; ex_wen = 1'b1; ex_is_load = 1'b1;
    #1;
    check("lu0_d1_stall_b", 64'(lu_stall_b), 64'd1);
    check("lu0_d1_stall_a", 64'(lu_stall_a), 64'd1);
    tick();
    ex_wen = 1'b0; ex_is_load = 1'b0;
    mem_wsel = 5'd5; mem_wen = 1'b1; mem_is_load = 1'b1;
    #1;
    check("lu0_d2_stall_b", 64'(lu_stall_b), 64'd1);
    check("lu0_d2_stall_a", 64'(lu_stall_a), 64'd0);
    tick();
    id_ruse = '0; mem_wen = 1'b0; mem_is_load = 1'b0;
    wb_wsel = 5'd5; wb_wen = 1'b1;
    ex_rsel = {5'd5, 5'd0}; ex_ruse = 2'b10;
    #1;
    check("lu0_release_b", 64'(lu_stall_b), 64'd0);
    check("lu0_fsel_b",    64'(fsel_b),     64'h4);
    check("lu0_bubble_b",  64'(bubble_b),   64'd2);
    check("lu0_bubble_a",  64'(bubble_a),   64'd1);
    tick();
    check("lu0_haz_b", 64'(haz_err_b), 64'd0);

    // Load-use, load may forward from MEM
    reset_dut();
    id_rsel = {5'd5, 5'd0}; id_ruse = 2'b10;
    ex_wsel = 5'd5; ex_wen = 1'b1; ex_is_load = 1'b1;
    #1;
    check("lu1_stall_a", 64'(lu_stall_a), 64'd1);
    tick();
    id_ruse = '0; ex_wen = 1'b0; ex_is_load = 1'b0;
    ex_rsel = {5'd5, 5'd0}; ex_ruse = 2'b10;
    mem_wsel = 5'd5; mem_wen = 1'b1; mem_is_load = 1'b1;
    #1;
    check("lu1_release_a", 64'(lu_stall_a), 64'd0);
    check("lu1_fsel_a",    64'(fsel_a),     64'h8);
    check("lu1_fsel_b",    64'(fsel_b),     64'h0);
    check("lu1_bubble_a",  64'(bubble_a),   64'd1);
    tick();
    check("lu1_haz_b", 64'(haz_err_b), 64'd1);
    check("lu1_haz_a", 64'(haz_err_a), 64'd0);

    // Bubble counter saturation (3-bit instance) and hold/flush suppression
    reset_dut();
    id_rsel = {5'd0, 5'd9}; id_ruse = 2'b01;
    ex_wsel = 5'd9; ex_wen = 1'b1; ex_is_load = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("sat_pre_c", 64'(bubble_c), 64'd6);
    check("sat_pre_a", 64'(bubble_a), 64'd6);
    ex_hold = 1'b1;
    #1;
    check("stall_under_hold_a", 64'(lu_stall_a), 64'd1);
    tick();
    check("hold_no_count_c", 64'(bubble_c), 64'd6);
    ex_hold = 1'b0; flush = 1'b1;
    tick();
    check("flush_no_count_a", 64'(bubble_a), 64'd6);
    flush = 1'b0;
    tick();
    check("sat_max_c", 64'(bubble_c), 64'd7);
    tick();
    check("sat_stay_c", 64'(bubble_c), 64'd7);
    check("sat_cnt_a",  64'(bubble_a), 64'd8);
    check("sat_cnt_b",  64'(bubble_b), 64'd8);

    // Hold capture over three held cycles, then release
    reset_dut();
    ex_rsel = {5'd0, 5'd7}; ex_ruse = 2'b01; ex_hold = 1'b1;
    wb_wsel = 5'd7; wb_wen = 1'b1; wb_wdat = 32'hDEADBEEF;
    #1;
    check("hold_c1_fsel", 64'(fsel_a), 64'h1);
    tick();
    wb_wen = 1'b0; wb_wdat = '0;
    #1;
    check("hold_c2_fsel", 64'(fsel_a), 64'h3);
    check("hold_c2_dat",  64'(hold_dat_a), 64'h00000000DEADBEEF);
    tick();
    #1;
    check("hold_c3_fsel", 64'(fsel_a), 64'h3);
    mem_wsel = 5'd7; mem_wen = 1'b1;
    #1;
    check("hold_mem_over", 64'(fsel_a), 64'h2);
    mem_wen = 1'b0;
    #1;
    check("hold_mem_gone", 64'(fsel_a), 64'h3);
    tick();
    ex_hold = 1'b0;
    #1;
    check("hold_rel_same", 64'(fsel_a), 64'h3);
    tick();
    check("hold_rel_next", 64'(fsel_a), 64'h0);

    // Recapture of a newer WB value on both operands, then flush
    ex_rsel = {5'd7, 5'd7}; ex_ruse = 2'b11; ex_hold = 1'b1;
    wb_wsel = 5'd7; wb_wen = 1'b1; wb_wdat = 32'hDEADBEEF;
    tick();
    wb_wdat = 32'h00001234;
    #1;
    check("recap_wb_fsel", 64'(fsel_a), 64'h5);
    tick();
    wb_wen = 1'b0;
    #1;
    check("recap_fsel", 64'(fsel_a), 64'hF);
    check("recap_dat",  64'(hold_dat_a), 64'h0000123400001234);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_fsel", 64'(fsel_a), 64'h0);

    // Asynchronous reset in the middle of a hold
    reset_dut();
    id_rsel = {5'd0, 5'd9}; id_ruse = 2'b01;
    ex_wsel = 5'd9; ex_wen = 1'b1; ex_is_load = 1'b1;
    ex_rsel = {5'd0, 5'd7}; ex_ruse = 2'b01;
    mem_wsel = 5'd7; mem_wen = 1'b1; mem_is_load = 1'b1;
    tick();
    idle();
    ex_rsel = {5'd0, 5'd7}; ex_ruse = 2'b01; ex_hold = 1'b1;
    wb_wsel = 5'd7; wb_wen = 1'b1; wb_wdat = 32'hCAFEF00D;
    tick();
    wb_wen = 1'b0;
    #1;
    check("pre_rst_fsel",   64'(fsel_a),    64'h3);
    check("pre_rst_bubble", 64'(bubble_a),  64'd1);
    check("pre_rst_haz_b",  64'(haz_err_b), 64'd1);
    nRST = 1'b0; ex_ruse = '0;
    #1;
    check("arst_fsel",     64'(fsel_a),     64'h0);
    check("arst_hold_dat", 64'(hold_dat_a), 64'h0);
    check("arst_bubble_a", 64'(bubble_a),   64'd0);
    check("arst_bubble_b", 64'(bubble_b),   64'd0);
    check("arst_haz_b",    64'(haz_err_b),  64'd0);
    check("arst_stall",    64'(lu_stall_a), 64'd0);
    nRST = 1'b1; ex_ruse = 2'b01;
    #1;
    check("arst_hold_v", 64'(fsel_a), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Parametrised successor to the single-issue forwarding unit.
- Computes per-operand forwarding selects for NSRC execute-stage operands, with priority MEM > WB > HOLD > RF.
- Detects load-use hazards and raises a stall to IF/ID.
- Keeps a per-operand hold buffer so a WB result is not lost while the EX instruction is held and later stages drain.
- Maintains a saturating bubble counter and a sticky hazard-error flag.

Parameters:
- AW, 5, register address width; address 0 is never a hazard.
- DW, 32, data width.
- NSRC, 2, operands per instruction, checked in both ID and EX.
- LOAD_FWD_MEM, 1, when 1 a load in MEM may forward; when 0 a load forwards from WB only.
- CNT_W, 16, bubble counter width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- id_rsel  in  NSRC*AW  ID operand addresses; operand i is bits [i*AW +: AW].
- id_ruse  in  NSRC  ID operand-used flags.
- ex_rsel  in  NSRC*AW  EX operand addresses.
- ex_ruse  in  NSRC  EX operand-used flags.
- ex_wsel  in  AW  EX destination address.
- ex_wen  in  1  EX destination write enable.
- ex_is_load  in  1  EX instruction is a load.
- mem_wsel  in  AW  MEM destination address.
- mem_wen  in  1  MEM destination write enable.
- mem_is_load  in  1  MEM instruction is a load.
- wb_wsel  in  AW  WB destination address.
- wb_wen  in  1  WB destination write enable.
- wb_wdat  in  DW  WB result data.
- ex_hold  in  1  EX instruction does not advance this cycle; MEM and WB still advance.
- flush  in  1  squash the EX instruction.
- fsel  out  2*NSRC  per-operand select: 0=RF, 1=WB, 2=MEM, 3=HOLD.
- hold_dat  out  NSRC*DW  per-operand held data, muxed in when fsel=3.
- lu_stall  out  1  freeze IF/ID and insert a bubble into EX.
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted.
- haz_err  out  1  sticky illegal-forward flag.

Behaviour:
- Reset (async, nRST=0) drives all registered state low:
  - hold_v, hold_dat = 0.
  - bubble_cnt = 0.
  - haz_err = 0.
- Outputs during reset: fsel = 0 and lu_stall = 0, given ex_ruse = id_ruse = 0.
- Match functions, for each operand i:
  - match_X(i) = ruse[i] && X_wen && X_wsel != 0 && X_wsel == rsel[i].
  - mem_ok = !mem_is_load || LOAD_FWD_MEM.
- fsel (combinational, same cycle), first rule that applies wins:
  - 2 if match_mem && mem_ok.
  - 1 if match_wb.
  - 3 if hold_v[i].
  - 0 otherwise.
- Hold capture, at the posedge:
  - If ex_hold=1 && !flush and fsel[i]==1: hold_dat[i] <= wb_wdat and hold_v[i] <= 1.
  - If ex_hold=1 && !flush and fsel[i] is any other value: hold state for operand i is unchanged.
  - A newer matching MEM or WB producer overrides HOLD by priority; when that producer reaches WB it is recaptured.
  - If ex_hold=0 or flush=1: all hold_v <= 0. Flush wins over ex_hold.
- Load-use stall (combinational) fires for any i with id_ruse[i] and either:
  - ex_is_load && match_ex(i), or
  - LOAD_FWD_MEM==0 && mem_is_load && match_mem(i) (address compared against id_rsel).
- Resulting bubbles: LOAD_FWD_MEM=1 gives 1 bubble at distance 1; LOAD_FWD_MEM=0 gives 2 bubbles at distance 1 and 1 bubble at distance 2.
- lu_stall is independent of ex_hold.
- bubble_cnt increments at the edge when lu_stall && !ex_hold && !flush, and saturates at all-ones.
- haz_err is set at the edge and stays set until reset when LOAD_FWD_MEM==0 and some EX operand has match_mem && mem_is_load. That case is unreachable if the stall is honoured.
- Simultaneous events:
  - flush with ex_hold: flush wins, hold is cleared.
  - A WB match on a cycle where hold_v is already set: WB is selected and recaptured.
- Reset mid-hold: hold_v is cleared immediately (async).

Test Plan:
- EX rs=3 used; MEM wsel=3 wen; WB wsel=3 wen -> fsel[1:0]=2. Drop MEM -> fsel[1:0]=1. rs=0 with all writers at 0 -> fsel[1:0]=0.
- LOAD_FWD_MEM=1: ID rt=5 used, EX load to 5 -> lu_stall=1 for exactly 1 cycle, bubble_cnt=1. Next cycle EX rt fsel=2.
- LOAD_FWD_MEM=0: same sequence -> lu_stall high 2 consecutive cycles, bubble_cnt=2. Consumer then sees fsel=1 with load in WB, and haz_err stays 0.
- ex_hold=1 for 3 cycles; WB wsel=7 wdat=0xDEADBEEF in cycle 1 only; EX rs=7 -> fsel=1 in cycle 1, fsel=3 with hold_dat=0xDEADBEEF in cycles 2-3. ex_hold=0 -> hold cleared next cycle.
- During a hold on reg 7, a new WB to 7 with 0x1234 -> fsel=1 that cycle, then fsel=3 with hold_dat=0x1234. Assert flush -> hold_v=0 and fsel=0.
- Force bubble_cnt to all-ones minus 1 with two more stalls -> saturates at 0xFFFF. Pulse nRST mid-hold -> all outputs 0 asynchronously.
